// File: rtl/sync_fifo_p.sv
// sync_fifo_p: single-clock FIFO with registered active-low status flags.
// Optional retransmit is built when FIFO_RETRANSMIT_EN is defined.
module sync_fifo_p #(
    parameter int WIDTH    = 9,
    parameter int DEPTH    = 512,
    parameter int AE_LEVEL = 4,
    parameter int AF_LEVEL = 4
) (
    input  logic                       CLK,
    input  logic                       RS_,
    input  logic [WIDTH-1:0]           D,
    input  logic                       W_,
    input  logic                       R_,
    input  logic                       RT_,
    output logic [WIDTH-1:0]           Q,
    output logic                       EF_,
    output logic                       FF_,
    output logic                       HF_,
    output logic                       AE_,
    output logic                       AF_,
    output logic [$clog2(DEPTH+1)-1:0] COUNT,
    output logic                       OVF,
    output logic                       UDF
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_HALF = CW'(DEPTH / 2);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);
    localparam logic [CW-1:0] CNT_AF   = CW'(DEPTH - AF_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr_nxt;
    logic [AW-1:0] wptr_nxt;
    logic [CW-1:0] count_nxt;

    logic x_strobe;
    logic wr_ok;
    logic rd_ok;
    logic rt_ok;
    logic wr_rej;
    logic rd_rej;
    logic wr_wrap;

    // Unknown strobes are treated as idle so they cannot corrupt state.
`ifdef SYNTHESIS
    assign x_strobe = 1'b0;
`else
    assign x_strobe = $isunknown({W_, R_});
`endif

`ifdef FIFO_RETRANSMIT_EN
    logic wrap;

    assign rt_ok = ~RT_ & ~wrap & ~x_strobe;

    always_ff @(posedge CLK or negedge RS_) begin
        if (!RS_) begin
            wrap <= 1'b0;
        end else if (wr_wrap) begin
            wrap <= 1'b1;
        end
    end
`else
    logic unused_rt;

    assign unused_rt = RT_;
    assign rt_ok     = 1'b0;
`endif

    assign wr_ok   = ~W_ & FF_ & ~x_strobe;
    assign rd_ok   = ~R_ & EF_ & ~x_strobe & ~rt_ok;
    assign wr_rej  = ~W_ & ~FF_ & ~x_strobe;
    assign rd_rej  = ~R_ & ~EF_ & ~x_strobe & ~rt_ok;
    assign wr_wrap = wr_ok & (wptr == PTR_LAST);

    always_comb begin
        wptr_nxt  = wptr;
        rptr_nxt  = rptr;
        count_nxt = COUNT;
        if (wr_ok) begin
            wptr_nxt = wr_wrap ? '0 : wptr + 1'b1;
        end
        if (rd_ok) begin
            rptr_nxt = (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
        end
        // A write that wraps wptr during retransmit means all DEPTH words are live.
        if (rt_ok) begin
            rptr_nxt  = '0;
            count_nxt = wr_wrap ? CNT_FULL : CW'(wptr_nxt);
        end else if (wr_ok && !rd_ok) begin
            count_nxt = COUNT + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_nxt = COUNT - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            mem[wptr] <= D;
        end
    end

    always_ff @(posedge CLK or negedge RS_) begin
        if (!RS_) begin
            rptr  <= '0;
            wptr  <= '0;
            COUNT <= '0;
            Q     <= '0;
            EF_   <= 1'b0;
            FF_   <= 1'b1;
            HF_   <= 1'b1;
            AE_   <= 1'b0;
            AF_   <= 1'b1;
            OVF   <= 1'b0;
            UDF   <= 1'b0;
        end else begin
            rptr  <= rptr_nxt;
            wptr  <= wptr_nxt;
            COUNT <= count_nxt;
            EF_   <= (count_nxt != '0);
            FF_   <= (count_nxt != CNT_FULL);
            HF_   <= (count_nxt <= CNT_HALF);
            AE_   <= (count_nxt > CNT_AE);
            AF_   <= (count_nxt < CNT_AF);
            if (rd_ok) begin
                Q <= mem[rptr];
            end
            if (wr_rej) begin
                OVF <= 1'b1;
            end
            if (rd_rej) begin
                UDF <= 1'b1;
            end
        end
    end

endmodule
